mul_share_ctrl: RTL and testbench

Shares one shift-add multiplier datapath among NREQ requesters.
- A round-robin arbiter accepts one operand pair at a time.
- The block runs N add/shift iterations and returns the 2N-bit unsigned product tagged with the requester id.
- It sits between the ALU-side clients and the multiplier datapath, replacing per-client multipliers.

---
 rtl/mul_share_pkg.sv | 19 +
 rtl/mul_rr_arbiter.sv | 36 +++
 rtl/mul_share_ctrl.sv | 131 +++++++++++++
 tb/tb_mul_share_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// rtl/mul_share_pkg.sv - shared types and width helpers for the multiplier sharing controller
package mul_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single requester still needs a one-bit id field.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/mul_rr_arbiter.sv
// rtl/mul_rr_arbiter.sv - combinational round-robin picker, search starts just above last_grant
module mul_rr_arbiter
  import mul_share_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  last_grant,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic found;
  int   pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      pos = int'(last_grant) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (en && !found && (i == pos) && req_valid[i]) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = IDW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - one shift-add multiplier shared by NREQ requesters via round-robin
// Optional MUL_SKIP_ZERO_EN: zero operands bypass the iterations and respond after one cycle.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREQ = 2,
  parameter int IDW  = idx_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_multiplier,
  input  logic [NREQ*N-1:0] req_multiplicand,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*N-1:0]    rsp_product,
  output logic              busy
);

  localparam int CW = cnt_width(N);

  state_t          state, state_next;
  logic [N-1:0]    mcand, mplr;
  logic [N:0]      acc;
  logic [CW-1:0]   cnt;
  logic [IDW-1:0]  id, last_grant, grant_idx;
  logic [NREQ-1:0] grant;
  logic [N-1:0]    sel_mplr, sel_mcand;
  logic [N:0]      sum;
  logic [2*N:0]    shifted;
  logic            take, last_iter, zero_op;

  mul_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_valid (req_valid),
    .last_grant(last_grant),
    .en        (state == IDLE),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign take      = |grant;
  assign busy      = (state != IDLE);
  assign last_iter = (cnt == CW'(N-1));

  always_comb begin
    sel_mplr  = '0;
    sel_mcand = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_mplr  = req_multiplier[i*N +: N];
        sel_mcand = req_multiplicand[i*N +: N];
      end
    end
  end

`ifdef MUL_SKIP_ZERO_EN
  assign zero_op = (sel_mplr == '0) || (sel_mcand == '0);
`else
  assign zero_op = 1'b0;
`endif

  // The carry out of the add lands in acc[N] and is shifted down into the product.
  assign sum     = mplr[0] ? (acc + {1'b0, mcand}) : acc;
  assign shifted = {sum, mplr} >> 1;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take) state_next = zero_op ? DONE : RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand       <= '0;
      mplr        <= '0;
      acc         <= '0;
      cnt         <= '0;
      id          <= '0;
      last_grant  <= IDW'(NREQ-1);
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            mcand      <= sel_mcand;
            mplr       <= sel_mplr;
            id         <= grant_idx;
            last_grant <= grant_idx;
            acc        <= '0;
            cnt        <= '0;
            if (zero_op) begin
              rsp_valid   <= 1'b1;
              rsp_id      <= grant_idx;
              rsp_product <= '0;
            end
          end
        end
        RUN: begin
          acc  <= shifted[2*N:N];
          mplr <= shifted[N-1:0];
          cnt  <= cnt + CW'(1);
          if (last_iter) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= id;
            rsp_product <= shifted[2*N-1:0];
          end
        end
        DONE: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb/tb_mul_share_ctrl.sv - directed self-checking bench for mul_share_ctrl (N=8, NREQ=2)
module tb_mul_share_ctrl;

  localparam int N    = 8;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_multiplier;
  logic [NREQ*N-1:0] req_multiplicand;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*N-1:0]    rsp_product;
  logic              busy;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mul_share_ctrl #(.N(N), .NREQ(NREQ)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_multiplier  (req_multiplier),
    .req_multiplicand(req_multiplicand),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_product     (rsp_product),
    .busy            (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a pair on requester r, wait for its grant, and drop valid after the accept edge.
  task automatic issue(input int r, input logic [N-1:0] mp, input logic [N-1:0] mc);
    int w;
    w = 0;
    req_multiplier[r*N +: N]   = mp;
    req_multiplicand[r*N +: N] = mc;
    req_valid[r]               = 1'b1;
    #1;
    while (!req_ready[r] && w < 50) begin
      @(posedge clk);
      #2;
      w++;
    end
    vec++;
    if (req_ready[r] !== 1'b1) begin
      errs++;
      $display("FAIL grant_wait r%0d: req_ready=%b, required bit %0d set", r, req_ready, r);
    end
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    req_multiplier = '0; req_multiplicand = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    vec++; if (req_ready !== 2'b00) begin errs++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    vec++; if (rsp_product !== 16'd0) begin errs++; $display("FAIL reset_product: got %0d want 0", rsp_product); end
    vec++; if (rsp_id !== 1'b0) begin errs++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single;
    int cnt, first_v;
    logic [2*N-1:0] prod;
    logic [IDW-1:0] pid;
    cnt = 0; first_v = 0; prod = '0; pid = '1;
    issue(0, 8'd13, 8'd11);
    vec++; if (req_ready !== 2'b00) begin errs++; $display("FAIL single_ready_pulse: got %b want 00", req_ready); end
    while (busy && cnt < 100) begin
      cnt++;
      if (rsp_valid && first_v == 0) begin
        first_v = cnt; prod = rsp_product; pid = rsp_id;
      end
      tick();
    end
    vec++; if (cnt !== 9) begin errs++; $display("FAIL single_busy_cycles: got %0d want 9", cnt); end
    vec++; if (first_v !== 9) begin errs++; $display("FAIL single_latency: got %0d want 9", first_v); end
    vec++; if (prod !== 16'd143) begin errs++; $display("FAIL single_product: got %0d want 143", prod); end
    vec++; if (pid !== 1'b0) begin errs++; $display("FAIL single_id: got %0d want 0", pid); end
  endtask

  task automatic test_boundary;
    int lat;
    issue(0, 8'd255, 8'd255);
    wait_rsp(lat);
    vec++; if (lat !== 9) begin errs++; $display("FAIL max_latency: got %0d want 9", lat); end
    vec++; if (rsp_product !== 16'hFE01) begin errs++; $display("FAIL max_product: got %h want fe01", rsp_product); end
    tick();
    issue(0, 8'd0, 8'd200);
    wait_rsp(lat);
`ifdef MUL_SKIP_ZERO_EN
    vec++; if (lat !== 1) begin errs++; $display("FAIL zero_latency: got %0d want 1", lat); end
`else
    vec++; if (lat !== 9) begin errs++; $display("FAIL zero_latency: got %0d want 9", lat); end
`endif
    vec++; if (rsp_product !== 16'd0) begin errs++; $display("FAIL zero_product: got %0d want 0", rsp_product); end
    tick();
  endtask

  task automatic test_round_robin;
    int w, lat;
    logic [NREQ-1:0] exp_g;
    rst = 1'b1; tick(); rst = 1'b0;
    req_multiplier   = {8'd5, 8'd3};
    req_multiplicand = {8'd6, 8'd4};
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (req_ready == '0 && w < 50) begin tick(); w++; end
      exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
      vec++; if (req_ready !== exp_g) begin errs++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, exp_g); end
      tick();
      wait_rsp(lat);
      vec++; if (rsp_id !== 1'(k % 2)) begin errs++; $display("FAIL rr_id%0d: got %0d want %0d", k, rsp_id, k % 2); end
      vec++;
      if (rsp_product !== ((k % 2 == 1) ? 16'd30 : 16'd12)) begin
        errs++; $display("FAIL rr_product%0d: got %0d want %0d", k, rsp_product, (k % 2 == 1) ? 30 : 12);
      end
      tick();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_back_pressure;
    int lat;
    rsp_ready = 1'b0;
    issue(0, 8'd9, 8'd10);
    req_multiplier[N +: N]   = 8'd2;
    req_multiplicand[N +: N] = 8'd3;
    req_valid[1] = 1'b1;
    wait_rsp(lat);
    vec++; if (lat !== 9) begin errs++; $display("FAIL bp_latency: got %0d want 9", lat); end
    for (int i = 0; i < 20; i++) begin
      vec++;
      if (rsp_valid !== 1'b1 || rsp_product !== 16'd90 || rsp_id !== 1'b0 || req_ready !== 2'b00) begin
        errs++;
        $display("FAIL bp_hold%0d: valid=%b product=%0d id=%0d ready=%b want 1/90/0/00",
                 i, rsp_valid, rsp_product, rsp_id, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL bp_release_valid: got %b want 0", rsp_valid); end
    vec++; if (req_ready !== 2'b10) begin errs++; $display("FAIL bp_next_grant: got %b want 10", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    wait_rsp(lat);
    vec++; if (rsp_product !== 16'd6) begin errs++; $display("FAIL bp_next_product: got %0d want 6", rsp_product); end
    vec++; if (rsp_id !== 1'b1) begin errs++; $display("FAIL bp_next_id: got %0d want 1", rsp_id); end
    tick();
  endtask

  task automatic test_reset_abort;
    logic saw;
    saw = 1'b0;
    issue(0, 8'd7, 8'd9);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL abort_busy: got %b want 0", busy); end
    vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL abort_valid: got %b want 0", rsp_valid); end
    vec++; if (rsp_product !== 16'd0) begin errs++; $display("FAIL abort_product: got %0d want 0", rsp_product); end
    vec++; if (rsp_id !== 1'b0) begin errs++; $display("FAIL abort_id: got %0d want 0", rsp_id); end
    vec++; if (req_ready !== 2'b00) begin errs++; $display("FAIL abort_ready: got %b want 00", req_ready); end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid) saw = 1'b1;
      tick();
    end
    vec++; if (saw !== 1'b0) begin errs++; $display("FAIL abort_no_rsp: saw rsp_valid=%b want 0", saw); end
    req_valid = 2'b11;
    #1;
    vec++; if (req_ready !== 2'b01) begin errs++; $display("FAIL abort_first_grant: got %b want 01", req_ready); end
    req_valid = 2'b00;
    tick();
  endtask

`ifdef MUL_SKIP_ZERO_EN
  task automatic test_skip_zero;
    int lat;
    issue(0, 8'd0, 8'h77);
    wait_rsp(lat);
    vec++; if (lat !== 1) begin errs++; $display("FAIL skip_latency: got %0d want 1", lat); end
    vec++; if (rsp_product !== 16'd0) begin errs++; $display("FAIL skip_product: got %0d want 0", rsp_product); end
    tick();
    issue(0, 8'd6, 8'd7);
    wait_rsp(lat);
    vec++; if (lat !== 9) begin errs++; $display("FAIL skip_nonzero_latency: got %0d want 9", lat); end
    vec++; if (rsp_product !== 16'd42) begin errs++; $display("FAIL skip_nonzero_product: got %0d want 42", rsp_product); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_round_robin();
    test_back_pressure();
    test_reset_abort();
`ifdef MUL_SKIP_ZERO_EN
    test_skip_zero();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
